// File: rtl/pipelined_prefix_adder.sv
// Fully pipelined Kogge-Stone adder on 2-bit kpg codes, one prefix level per register stage,
// with a global valid/ready stall. Define PPA_SUB_EN to add the sub (subtract-select) port.
module pipelined_prefix_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PPA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int L = $clog2(WIDTH);

   // Position p holds bit p-1; position 0 is the carry-in pseudo-bit.
   typedef logic [WIDTH:0][1:0] kpg_vec_t;

   function automatic logic [1:0] combine(input logic [1:0] upper, input logic [1:0] lower);
      return (upper == 2'b00 || upper == 2'b11) ? upper : lower;
   endfunction

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef PPA_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub | cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   kpg_vec_t kpg_in;

   always_comb begin
      kpg_in[0] = {cin_eff, cin_eff};
      for (int i = 0; i < WIDTH; i++) begin
         kpg_in[i+1] = {a[i], b_eff[i]};
      end
   end

   kpg_vec_t         kpg_q   [0:L];
   kpg_vec_t         kpg_d   [1:L];
   logic [WIDTH-1:0] a_q     [0:L];
   logic [WIDTH-1:0] b_q     [0:L];
   logic             valid_q [0:L];
   logic             adv;

   for (genvar k = 1; k <= L; k++) begin : g_level
      localparam int SPAN = 1 << (k - 1);
      kpg_vec_t nxt;
      for (genvar p = 0; p <= WIDTH; p++) begin : g_pos
         if (p >= SPAN) begin : g_comb
            assign nxt[p] = combine(kpg_q[k-1][p], kpg_q[k-1][p-SPAN]);
         end else begin : g_pass
            assign nxt[p] = kpg_q[k-1][p];
         end
      end
      assign kpg_d[k] = nxt;
   end

   // One advance for every stage: a stalled output freezes the whole pipe, bubbles included.
   assign adv      = !valid_q[L] || out_ready;
   assign in_ready = adv;

   // NOTE: data registers are reset along with the valid bits so sum/cout/ovf read 0 out of reset;
   // all state uses non-blocking assignment so every stage samples the previous stage's old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s <= L; s++) begin
            valid_q[s] <= 1'b0;
            kpg_q[s]   <= '0;
            a_q[s]     <= '0;
            b_q[s]     <= '0;
         end
      end else if (adv) begin
         valid_q[0] <= in_valid;
         kpg_q[0]   <= kpg_in;
         a_q[0]     <= a;
         b_q[0]     <= b_eff;
         for (int s = 1; s <= L; s++) begin
            valid_q[s] <= valid_q[s-1];
            kpg_q[s]   <= kpg_d[s];
            a_q[s]     <= a_q[s-1];
            b_q[s]     <= b_q[s-1];
         end
      end
   end

   logic [WIDTH-1:0] carry;
   logic [1:0]       msb_grp;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         carry[i] = kpg_q[L][i][0];
      end
   end

   // The top position spans bits WIDTH-1..0 only; a still-propagating group takes the carry-in.
   assign msb_grp   = kpg_q[L][WIDTH];
   assign cout      = (msb_grp == 2'b00 || msb_grp == 2'b11) ? msb_grp[0] : kpg_q[L][0][0];
   assign sum       = a_q[L] ^ b_q[L] ^ carry;
   assign ovf       = carry[WIDTH-1] ^ cout;
   assign out_valid = valid_q[L];

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: WIDTH 16/8/64 instances, directed vector table, random traffic
// against an arithmetic reference model, back-pressure and mid-flight reset sequences.
module tb_pipelined_prefix_adder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] a, b;
   logic        cin;
   logic        sub_v;
   int          sel;

   always #5 clk = ~clk;

   logic        iv16, iv8, iv64;
   logic        ir16, ir8, ir64, ov16, ov8, ov64, co16, co8, co64, of16, of8, of64;
   logic [15:0] s16;
   logic [7:0]  s8;
   logic [63:0] s64;

   assign iv16 = in_valid && (sel == 16);
   assign iv8  = in_valid && (sel == 8);
   assign iv64 = in_valid && (sel == 64);

   pipelined_prefix_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]), .cin(cin),
`ifdef PPA_SUB_EN
      .sub(sub_v),
`endif
      .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16));

   pipelined_prefix_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]), .cin(cin),
`ifdef PPA_SUB_EN
      .sub(sub_v),
`endif
      .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8));

   pipelined_prefix_adder #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .a(a), .b(b), .cin(cin),
`ifdef PPA_SUB_EN
      .sub(sub_v),
`endif
      .out_valid(ov64), .out_ready(out_ready), .sum(s64), .cout(co64), .ovf(of64));

   // Outputs of whichever instance the current test drives.
   logic        ov_s, ir_s, co_s, of_s;
   logic [63:0] sum_s;

   always_comb begin
      ov_s = ov16; ir_s = ir16; co_s = co16; of_s = of16; sum_s = {48'b0, s16};
      case (sel)
         8:  begin ov_s = ov8;  ir_s = ir8;  co_s = co8;  of_s = of8;  sum_s = {56'b0, s8}; end
         64: begin ov_s = ov64; ir_s = ir64; co_s = co64; of_s = of64; sum_s = s64; end
         default: ;
      endcase
   end

   typedef struct packed {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [63:0] a, b;
      logic        cin;
      logic [63:0] sum;
      logic        cout, ovf;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain w-bit modular arithmetic with two's-complement overflow from operand signs.
   function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                  input logic ci, input logic s);
      logic [63:0] mask;
      logic [64:0] full;
      res_t        r;
      mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      x      = x & mask;
      y      = (s ? ~y : y) & mask;
      full   = {1'b0, x} + {1'b0, y} + {64'b0, (s | ci)};
      r.sum  = full[63:0] & mask;
      r.cout = full[w];
      r.ovf  = (x[w-1] == y[w-1]) && (r.sum[w-1] != x[w-1]);
      return r;
   endfunction

   res_t q16[$], q8[$], q64[$];

   // Scoreboard: accepts and drains are both decided by levels that are stable at the falling edge.
   always @(negedge clk) begin
      res_t e;
      if (!reset) begin
         q16.delete(); q8.delete(); q64.delete();
      end else begin
         if (ov16 && out_ready) begin
            if (q16.size() == 0) check("spurious16", {63'b0, ov16}, 64'd0);
            else begin
               e = q16.pop_front();
               check("sum16", {48'b0, s16}, e.sum); check("cout16", {63'b0, co16}, {63'b0, e.cout});
               check("ovf16", {63'b0, of16}, {63'b0, e.ovf});
            end
         end
         if (ov8 && out_ready) begin
            if (q8.size() == 0) check("spurious8", {63'b0, ov8}, 64'd0);
            else begin
               e = q8.pop_front();
               check("sum8", {56'b0, s8}, e.sum); check("cout8", {63'b0, co8}, {63'b0, e.cout});
               check("ovf8", {63'b0, of8}, {63'b0, e.ovf});
            end
         end
         if (ov64 && out_ready) begin
            if (q64.size() == 0) check("spurious64", {63'b0, ov64}, 64'd0);
            else begin
               e = q64.pop_front();
               check("sum64", s64, e.sum); check("cout64", {63'b0, co64}, {63'b0, e.cout});
               check("ovf64", {63'b0, of64}, {63'b0, e.ovf});
            end
         end
         if (iv16 && ir16) q16.push_back(model(16, a, b, cin, sub_v));
         if (iv8  && ir8)  q8.push_back(model(8, a, b, cin, sub_v));
         if (iv64 && ir64) q64.push_back(model(64, a, b, cin, sub_v));
      end
   end

   function automatic int lat_of(input int w);
      return $clog2(w) + 1;
   endfunction

   task automatic one_beat(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s,
                           input logic [63:0] es, input logic ec, input logic eo, input string nm);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; a = x; b = y; cin = c; sub_v = s;
      @(posedge clk); #1;
      in_valid = 1'b0; sub_v = 1'b0;
      n = 1;
      while (!ov_s && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_lat"}, 64'(n), 64'(lat_of(sel)));
      check({nm, "_sum"}, sum_s, es);
      check({nm, "_cout"}, {63'b0, co_s}, {63'b0, ec});
      check({nm, "_ovf"}, {63'b0, of_s}, {63'b0, eo});
   endtask

   task automatic throughput(input int nbeats);
      int first, last, ones;
      first = -1; last = -1; ones = 0;
      for (int t = 0; t < nbeats + 4 * lat_of(sel); t++) begin
         if (t < nbeats) begin
            in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
         end else in_valid = 1'b0;
         @(posedge clk); #1;
         if (ov_s) begin
            if (first < 0) first = t;
            last = t;
            ones++;
         end
      end
      check("tput_first", 64'(first), 64'(lat_of(sel) - 1));
      check("tput_count", 64'(ones), 64'(nbeats));
      check("tput_span", 64'(last - first + 1), 64'(nbeats));
   endtask

   task automatic reset_flight();
      int lat, ones, first;
      lat = lat_of(sel);
      out_ready = 1'b0;
      for (int i = 0; i < lat; i++) begin
         in_valid = 1'b1; a = {$urandom, $urandom} | 64'h11; b = {$urandom, $urandom} | 64'h3; cin = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("rf_full", {63'b0, ov_s}, 64'd1);
      reset = 1'b0;
      #1;
      check("rf_valid", {63'b0, ov_s}, 64'd0);
      check("rf_sum", sum_s, 64'd0);
      check("rf_cout", {63'b0, co_s}, 64'd0);
      check("rf_ovf", {63'b0, of_s}, 64'd0);
      check("rf_in_ready", {63'b0, ir_s}, 64'd1);
      @(posedge clk); #1;
      reset = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b0;
      ones = 0; first = -1;
      for (int t = 0; t < 3 * lat; t++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (ov_s) begin
            if (first < 0) first = t;
            ones++;
         end
      end
      check("rf_after_count", 64'(ones), 64'd1);
      check("rf_after_lat", 64'(first), 64'(lat - 1));
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0};
      tbl[1] = '{64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1};
      tbl[2] = '{64'h0000, 64'h0000, 1'b1, 64'h0001, 1'b0, 1'b0};
      tbl[3] = '{64'h8000, 64'h8000, 1'b0, 64'h0000, 1'b1, 1'b1};
      tbl[4] = '{64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1, 1'b0};
      tbl[5] = '{64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0};
      tbl[6] = '{64'h7FFF, 64'h7FFF, 1'b1, 64'hFFFF, 1'b0, 1'b1};
      tbl[7] = '{64'h8000, 64'hFFFF, 1'b0, 64'h7FFF, 1'b1, 1'b1};

      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
      sel = 16;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {63'b0, ov_s}, 64'd0);
      check("rst_sum", sum_s, 64'd0);
      check("rst_cout", {63'b0, co_s}, 64'd0);
      check("rst_ovf", {63'b0, of_s}, 64'd0);
      check("rst_in_ready", {63'b0, ir_s}, 64'd1);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         one_beat(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, tbl[i].sum, tbl[i].cout, tbl[i].ovf, $sformatf("vec%0d", i));
      end

`ifdef PPA_SUB_EN
      one_beat(64'h0005, 64'h0007, 1'b0, 1'b1, 64'hFFFE, 1'b0, 1'b0, "sub_a");
      one_beat(64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1, "sub_b");
`endif

      @(posedge clk); #1;
      throughput(8);

      // Back-pressure: hold the output for 3 cycles while a feeder keeps offering beats.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               bit got;
               int tries;
               in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
               got = 1'b0; tries = 0;
               while (!got && tries < 50) begin
                  @(negedge clk);
                  got = ir_s;
                  @(posedge clk); #1;
                  tries++;
               end
               if (!got) check("bp_accept_timeout", 64'd0, 64'd1);
            end
            in_valid = 1'b0;
         end
         begin
            int n;
            n = 0;
            while (!ov_s && n < 50) begin
               @(posedge clk); #1;
               n++;
            end
            check("bp_seen_valid", {63'b0, ov_s}, 64'd1);
            out_ready = 1'b0;
            #1;
            for (int j = 0; j < 3; j++) begin
               check("bp_valid", {63'b0, ov_s}, 64'd1);
               check("bp_in_ready", {63'b0, ir_s}, 64'd0);
               if (q16.size() == 0) check("bp_queue", 64'd0, 64'd1);
               else begin
                  check("bp_sum", sum_s, q16[0].sum);
                  check("bp_cout", {63'b0, co_s}, {63'b0, q16[0].cout});
                  check("bp_ovf", {63'b0, of_s}, {63'b0, q16[0].ovf});
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      #1;
      check("bp_drain", 64'(q16.size()), 64'd0);

      reset_flight();

      sel = 8;
      throughput(12);
      reset_flight();

      sel = 64;
      throughput(12);
      reset_flight();

      repeat (10) @(posedge clk);
      #1;
      check("end_q16", 64'(q16.size()), 64'd0);
      check("end_q8", 64'(q8.size()), 64'd0);
      check("end_q64", 64'(q64.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
